prog_loader: RTL and testbench

Program loader that fills instruction memory from an 8-bit byte stream before the processor runs. It sits between an external byte source (debug/test port) and the write side of the instruction memory's request/acknowledge interface. It writes the words the processor later fetches through the same interface's read side. While loading it holds the processor in reset, then releases it and pulses `done`.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_byte_packer.sv | 51 +++++
 rtl/prog_loader.sv | 179 +++++++++++++++++
 tb/tb_prog_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and stream framing constants.
package prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEN0  = 3'd1;
  localparam state_t ST_LEN1  = 3'd2;
  localparam state_t ST_BYTE  = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Header carries the word count as little-endian bytes.
  localparam int unsigned HDR_LEN    = 2;
  localparam int unsigned LEN_W      = 8 * HDR_LEN;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word (first byte lands in [7:0]).
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  // Qualifies the byte that completes the word, so the caller can act in the same cycle.
  assign last_byte  = byte_en && !valid_q && (cnt_q == 2'(WORD_BYTES - 1));
  assign word       = word_q;
  assign word_valid = valid_q;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (clr) begin
      cnt_d   = '0;
      word_d  = '0;
      valid_d = 1'b0;
    end else if (byte_en && !valid_q) begin
      word_d  = {byte_in, word_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Fills instruction memory from a length-prefixed byte stream while holding the CPU in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Timeout counter only needs to reach TIMEOUT-1.
  localparam int          TMO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W:0]    addr_q, addr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               wr_en_q, wr_en_d;
  logic               hold_q, hold_d;
  logic               err_q, err_d;

  logic               pk_clr;
  logic               pk_en;
  logic               pk_last;
  logic               pk_valid;
  logic [31:0]        pk_word;
  logic               byte_fire;
  logic [LEN_W-1:0]   new_len;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (pk_clr),
    .byte_en    (pk_en),
    .byte_in    (byte_data),
    .word       (pk_word),
    .last_byte  (pk_last),
    .word_valid (pk_valid)
  );

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      ST_LEN0, ST_LEN1: byte_ready = 1'b1;
      ST_BYTE:          byte_ready = !pk_valid;
      default:          byte_ready = 1'b0;
    endcase
  end

  assign byte_fire   = byte_valid && byte_ready;
  assign pk_en       = byte_fire && (state_q == ST_BYTE);
  assign new_len     = {byte_data, len_q[7:0]};

  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q[ADDR_W-1:0];
  // The packer register holds the word untouched for the whole WRITE state.
  assign mem_wr_data = pk_word;
  assign cpu_hold    = hold_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign error       = err_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    wr_en_d = wr_en_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pk_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          addr_d  = '0;
        end
      end

      ST_LEN0: begin
        if (byte_fire) begin
          len_d   = {len_q[LEN_W-1:8], byte_data};
          state_d = ST_LEN1;
        end
      end

      ST_LEN1: begin
        if (byte_fire) begin
          len_d = new_len;
          if (new_len == '0) begin
            state_d = ST_DONE;
          end else if (32'(new_len) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BYTE;
            pk_clr  = 1'b1;
          end
        end
      end

      ST_BYTE: begin
        if (pk_last) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          tmo_d   = '0;
        end
      end

      ST_WRITE: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          wr_en_d = 1'b0;
          addr_d  = addr_q + 1'b1;
          if (32'(addr_q) + 32'd1 == 32'(len_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BYTE;
            pk_clr  = 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          wr_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_DONE: begin
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
      wr_en_q <= 1'b0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      wr_en_q <= wr_en_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: streams framed images against a behavioural ack responder.
module tb_prog_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 8;
  localparam int BIG     = 1 << 30;

  logic              clk;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  wire               mem_ack;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  logic resp_ack;
  logic stray_ack;
  assign mem_ack = resp_ack | stray_ack;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_ack     (mem_ack),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_base;
  int ack_delay;
  int ack_budget;
  int wait_cnt;
  int stab_viol;
  int rdy_viol;
  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_data;
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  int                log_cyc[$];
  logic [7:0]        stim[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  // Memory side: acks after ack_delay wait cycles and watches request stability.
  initial begin
    resp_ack = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_wr_en === 1'b1 && reset === 1'b1) begin
        if (byte_ready !== 1'b0) rdy_viol++;
        if (wait_cnt == 0) begin
          hold_addr = mem_addr;
          hold_data = mem_wr_data;
        end else if (mem_addr !== hold_addr || mem_wr_data !== hold_data) begin
          stab_viol++;
        end
        if (!resp_ack && wait_cnt >= ack_delay && log_addr.size() < ack_budget) begin
          resp_ack = 1'b1;
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wr_data);
          log_cyc.push_back(cyc);
        end
        wait_cnt++;
      end else begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic new_test(input int dly, input int budget);
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    stab_viol  = 0;
    rdy_viol   = 0;
    ack_delay  = dly;
    ack_budget = budget;
    done_base  = done_cnt;
  endtask

  task automatic push_len(input int n);
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int   guard;
    logic rdy;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard      = 0;
    forever begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 500) begin
        check_val("byte_accept_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_stim(input bit gap);
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gap);
    stim.delete();
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d);
    if (idx >= log_addr.size()) begin
      check_val({tag, "_present"}, 64'(log_addr.size()), 64'(idx + 1));
    end else begin
      check_val({tag, "_addr"}, 64'(log_addr[idx]), 64'(a));
      check_val({tag, "_data"}, 64'(log_data[idx]), 64'(d));
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return {8'(i), 8'hC3, 8'(i >> 8), 8'(~i)};
  endfunction

  initial begin
    int n;
    int bad_a;
    int bad_d;
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    stray_ack  = 1'b0;
    new_test(1, BIG);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_byte_ready", 64'(byte_ready), 64'd0);
    check_val("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_error", 64'(error), 64'd0);
    check_val("rst_addr", 64'(mem_addr), 64'd0);
    check_val("rst_data", 64'(mem_wr_data), 64'd0);
    check_val("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("idle_cpu_hold", 64'(cpu_hold), 64'd1);

    // Basic two-word load, ack one cycle after request.
    new_test(1, BIG);
    start_load();
    push_len(2);
    push_word(32'h12345678);
    push_word(32'hDEADBEEF);
    send_stim(1'b0);
    wait_idle("t1");
    check_val("t1_nwr", 64'(log_addr.size()), 64'd2);
    check_wr("t1_w0", 0, 10'd0, 32'h12345678);
    check_wr("t1_w1", 1, 10'd1, 32'hDEADBEEF);
    check_val("t1_done", 64'(done_cnt - done_base), 64'd1);
    check_val("t1_cpu_hold", 64'(cpu_hold), 64'd0);
    check_val("t1_error", 64'(error), 64'd0);
    check_val("t1_stable", 64'(stab_viol), 64'd0);

    // Zero-wait memory with a continuous stream: one word per 5 cycles.
    new_test(0, BIG);
    start_load();
    push_len(3);
    push_word(32'h0A0B0C0D);
    push_word(32'h11223344);
    push_word(32'hCAFEF00D);
    send_stim(1'b0);
    wait_idle("t1z");
    check_val("t1z_nwr", 64'(log_addr.size()), 64'd3);
    check_wr("t1z_w2", 2, 10'd2, 32'hCAFEF00D);
    if (log_cyc.size() == 3) begin
      check_val("t1z_period0", 64'(log_cyc[1] - log_cyc[0]), 64'd5);
      check_val("t1z_period1", 64'(log_cyc[2] - log_cyc[1]), 64'd5);
    end

    // Seven wait states and a byte stream with gaps.
    new_test(7, BIG);
    start_load();
    push_len(2);
    push_word(32'h12345678);
    push_word(32'hDEADBEEF);
    send_stim(1'b1);
    wait_idle("t2");
    check_wr("t2_w0", 0, 10'd0, 32'h12345678);
    check_wr("t2_w1", 1, 10'd1, 32'hDEADBEEF);
    check_val("t2_stable", 64'(stab_viol), 64'd0);
    check_val("t2_rdy_low", 64'(rdy_viol), 64'd0);
    check_val("t2_done", 64'(done_cnt - done_base), 64'd1);

    // Ack never arrives: request is withdrawn after TIMEOUT cycles.
    new_test(1, 0);
    start_load();
    push_len(1);
    push_word(32'h44332211);
    send_stim(1'b0);
    n = 0;
    while (mem_wr_en && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("t3_req_cycles", 64'(n), 64'(TIMEOUT));
    check_val("t3_error", 64'(error), 64'd1);
    check_val("t3_cpu_hold", 64'(cpu_hold), 64'd1);
    check_val("t3_busy", 64'(busy), 64'd0);
    check_val("t3_nwr", 64'(log_addr.size()), 64'd0);
    start_load();
    check_val("t3_err_clr", 64'(error), 64'd0);

    // Zero-length image finishes without writing.
    new_test(1, BIG);
    push_len(0);
    send_stim(1'b0);
    wait_idle("t4a");
    check_val("t4a_done", 64'(done_cnt - done_base), 64'd1);
    check_val("t4a_nwr", 64'(log_addr.size()), 64'd0);
    check_val("t4a_cpu_hold", 64'(cpu_hold), 64'd0);

    // One word more than the memory holds.
    new_test(1, BIG);
    start_load();
    push_len(1025);
    send_stim(1'b0);
    @(posedge clk); #1;
    check_val("t4b_error", 64'(error), 64'd1);
    check_val("t4b_busy", 64'(busy), 64'd0);
    check_val("t4b_nwr", 64'(log_addr.size()), 64'd0);
    check_val("t4b_done", 64'(done_cnt - done_base), 64'd0);
    check_val("t4b_cpu_hold", 64'(cpu_hold), 64'd1);

    // Full memory image.
    new_test(0, BIG);
    start_load();
    push_len(1024);
    for (int i = 0; i < 1024; i++) push_word(pat(i));
    send_stim(1'b0);
    wait_idle("t4c");
    check_val("t4c_nwr", 64'(log_addr.size()), 64'd1024);
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i] !== 10'(i)) bad_a++;
      if (log_data[i] !== pat(i)) bad_d++;
    end
    check_val("t4c_addr_seq", 64'(bad_a), 64'd0);
    check_val("t4c_data_seq", 64'(bad_d), 64'd0);
    check_wr("t4c_last", 1023, 10'd1023, pat(1023));
    check_val("t4c_done", 64'(done_cnt - done_base), 64'd1);
    check_val("t4c_error", 64'(error), 64'd0);

    // Reset while the second write is outstanding.
    new_test(1, 1);
    start_load();
    push_len(2);
    push_word(32'hA1B2C3D4);
    push_word(32'h0BADF00D);
    send_stim(1'b0);
    check_val("t5_pre_wr_en", 64'(mem_wr_en), 64'd1);
    check_val("t5_pre_addr", 64'(mem_addr), 64'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_val("t5_wr_en", 64'(mem_wr_en), 64'd0);
    check_val("t5_addr", 64'(mem_addr), 64'd0);
    check_val("t5_data", 64'(mem_wr_data), 64'd0);
    check_val("t5_busy", 64'(busy), 64'd0);
    check_val("t5_cpu_hold", 64'(cpu_hold), 64'd1);
    check_val("t5_byte_ready", 64'(byte_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    new_test(1, BIG);
    start_load();
    push_len(1);
    push_word(32'h5A5AA5A5);
    send_stim(1'b0);
    wait_idle("t5b");
    check_val("t5b_nwr", 64'(log_addr.size()), 64'd1);
    check_wr("t5b_w0", 0, 10'd0, 32'h5A5AA5A5);
    check_val("t5b_done", 64'(done_cnt - done_base), 64'd1);

    // Stray start and stray ack in the middle of a word.
    new_test(1, BIG);
    start_load();
    push_len(2);
    send_stim(1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    start     = 1'b1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    stray_ack = 1'b0;
    check_val("t6_busy", 64'(busy), 64'd1);
    check_val("t6_byte_ready", 64'(byte_ready), 64'd1);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    push_word(32'hDEADBEEF);
    send_stim(1'b0);
    wait_idle("t6");
    check_val("t6_nwr", 64'(log_addr.size()), 64'd2);
    check_wr("t6_w0", 0, 10'd0, 32'h12345678);
    check_wr("t6_w1", 1, 10'd1, 32'hDEADBEEF);
    check_val("t6_done", 64'(done_cnt - done_base), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
